// File: rtl/mem_stage.sv
// Memory stage load/store unit: one outstanding bus transfer through an IDLE/BUSY/DONE FSM.
// Optional build macro MEM_TIMEOUT_EN enables the BUSY-cycle timeout abort (o_bus_err).
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_alu_result_DM,
  input  logic [31:0] i_rs2_data_DM,
  input  logic        i_lsu_wren_DM,
  input  logic        i_data_sel_DM,
  input  logic [2:0]  i_funct3_DM,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_ld_data,
  output logic        o_stall_mem,
  output logic        o_access_fault,
  output logic        o_bus_err,
  output logic [1:0]  dbg_state
);

  // Bus handshake: o_bus_req rises in BUSY and holds every bus output stable until the
  // single-cycle i_bus_ack; ack outside BUSY has no effect.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        req_any, legal, aligned, access_ok, fault_nxt, timeout_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt, lane, ld_ext;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;

  assign dbg_state = state;

  always_comb begin
    req_any   = i_lsu_wren_DM | i_data_sel_DM;
    legal     = (i_funct3_DM == 3'b000) || (i_funct3_DM == 3'b001) || (i_funct3_DM == 3'b010) ||
                (i_funct3_DM == 3'b100) || (i_funct3_DM == 3'b101);
    aligned   = 1'b0;
    be_nxt    = 4'b1111;
    wdata_nxt = i_rs2_data_DM;
    case (i_funct3_DM[1:0])
      2'b00: begin
        aligned   = 1'b1;
        be_nxt    = 4'b0001 << i_alu_result_DM[1:0];
        wdata_nxt = {4{i_rs2_data_DM[7:0]}};
      end
      2'b01: begin
        aligned   = ~i_alu_result_DM[0];
        be_nxt    = 4'b0011 << i_alu_result_DM[1:0];
        wdata_nxt = {2{i_rs2_data_DM[15:0]}};
      end
      2'b10:   aligned = (i_alu_result_DM[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    access_ok = req_any & legal & aligned;
  end

  // Lane select uses the latched low address bits, not the live EX/MEM value.
  always_comb begin
    lane = i_bus_rdata >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'd0, lane[7:0]};
      3'b101:  ld_ext = {16'd0, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_stall_mem = 1'b0;
    fault_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (access_ok) begin
          state_nxt   = BUSY;
          o_stall_mem = 1'b1;
        end else begin
          fault_nxt = req_any;
        end
      end
      BUSY: begin
        o_stall_mem = 1'b1;
        if (i_bus_ack || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] busy_cnt;
  // Counter holds (cycles spent in BUSY - 1), so the limit fires on the TIMEOUT_CYCLES-th cycle.
  assign timeout_hit = (busy_cnt == CW'(TIMEOUT_CYCLES - 1)) && !i_bus_ack;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign o_bus_err          = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bus_req      <= 1'b0;
      o_bus_we       <= 1'b0;
      o_bus_addr     <= 32'd0;
      o_bus_wdata    <= 32'd0;
      o_bus_be       <= 4'd0;
      o_ld_data      <= 32'd0;
      o_access_fault <= 1'b0;
      addr_lo_q      <= 2'd0;
      funct3_q       <= 3'd0;
`ifdef MEM_TIMEOUT_EN
      o_bus_err      <= 1'b0;
      busy_cnt       <= '0;
`endif
    end else begin
      o_access_fault <= fault_nxt;
`ifdef MEM_TIMEOUT_EN
      o_bus_err      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (access_ok) begin
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_lsu_wren_DM;
            o_bus_addr  <= {i_alu_result_DM[31:2], 2'b00};
            o_bus_wdata <= wdata_nxt;
            o_bus_be    <= be_nxt;
            addr_lo_q   <= i_alu_result_DM[1:0];
            funct3_q    <= i_funct3_DM;
`ifdef MEM_TIMEOUT_EN
            busy_cnt    <= '0;
`endif
          end
        end
        BUSY: begin
          if (i_bus_ack) begin
            o_bus_req <= 1'b0;
            if (!o_bus_we) o_ld_data <= ld_ext;
          end else if (timeout_hit) begin
            o_bus_req <= 1'b0;
            o_ld_data <= 32'd0;
`ifdef MEM_TIMEOUT_EN
            o_bus_err <= 1'b1;
`endif
          end else begin
`ifdef MEM_TIMEOUT_EN
            busy_cnt <= busy_cnt + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, sets the number of BUSY cycles without acknowledge before abort (used only with MEM_TIMEOUT_EN).
REQ-002 Clocking and reset SHALL be one clock, with reset synchronous and active-high.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  in  1  synchronous active-high reset.
REQ-005 i_alu_result_DM  in  32  access byte address from EX/MEM register.
REQ-006 i_rs2_data_DM  in  32  store data.
REQ-007 i_lsu_wren_DM  in  1  store request.
REQ-008 i_data_sel_DM  in  1  load request; if both requests are high, store wins.
REQ-009 i_funct3_DM  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 o_bus_req, o_bus_we  out  1 each  registered bus request and write-enable.
REQ-011 o_bus_addr  out  32  word-aligned address, bits [1:0] = 00.
REQ-012 o_bus_wdata  out  32  lane-replicated store data.
REQ-013 o_bus_be  out  4  byte enables.
REQ-014 i_bus_ack  in  1  one-cycle transfer complete.
REQ-015 i_bus_rdata  in  32  read data, valid with i_bus_ack.
REQ-016 o_ld_data  out  32  extended load result.
REQ-017 o_stall_mem  out  1  hold request to hazard unit.
REQ-018 o_access_fault  out  1  one-cycle pulse for a misaligned or illegal access.
REQ-019 o_bus_err  out  1  one-cycle timeout pulse.

Function
REQ-020 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-021 An access SHALL be valid when (load or store) is set, funct3 is legal, and the address is aligned: H needs addr[0]=0, W needs addr[1:0]=00.
REQ-022 IDLE with a valid access SHALL go to BUSY next cycle, latching address, wdata, be, we and funct3; o_stall_mem is combinationally 1 in that IDLE cycle.
REQ-023 BUSY SHALL hold o_bus_req=1 with all bus outputs stable and o_stall_mem=1.
REQ-024 BUSY with i_bus_ack SHALL capture rdata and go to DONE; o_bus_req drops in DONE.
REQ-025 DONE SHALL drive o_stall_mem=0 and o_ld_data valid, ignore the inputs for one cycle, then go to IDLE.
REQ-026 Load latency SHALL be ack cycle + 1.
REQ-027 i_bus_ack outside BUSY SHALL be ignored.
REQ-028 Byte enables SHALL be: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111.
REQ-029 Store data SHALL be: B {4{rs2[7:0]}}; H {2{rs2[15:0]}}; W rs2.
REQ-030 Load data SHALL take the lane selected by the latched addr[1:0], sign-extended for B/H and zero-extended for BU/HU; o_ld_data is held until the next DONE.
REQ-031 A misaligned access, or funct3 011/110/111 with a request set, in IDLE SHALL pulse o_access_fault for one cycle, issue no bus request, keep o_stall_mem=0, and stay in IDLE; o_ld_data is unchanged.

Reset
REQ-032 Reset SHALL force state IDLE and drive o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be, o_ld_data, o_access_fault and o_bus_err to 0.
REQ-033 Reset SHALL clear the timeout counter.
REQ-034 Reset in BUSY SHALL abandon the transfer, with o_bus_req=0 in the following cycle.

Configuration
REQ-035 With MEM_TIMEOUT_EN defined, an 8-bit-minimum counter SHALL clear on BUSY entry and increment each BUSY cycle.
REQ-036 With MEM_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without ack SHALL go to DONE, pulse o_bus_err and load o_ld_data=0.
REQ-037 With MEM_TIMEOUT_EN defined, an ack in the same cycle as the limit SHALL win: normal completion, no error.
REQ-038 Without MEM_TIMEOUT_EN, BUSY SHALL wait indefinitely and o_bus_err SHALL be tied to 0.

Verification
REQ-039 LB from addr 0x103 with ack after 2 cycles and rdata 0x80112233 -> be 1000, addr 0x100, o_ld_data 0xFFFFFF80, stall high 3 cycles then low.
REQ-040 SH at addr 0x202 with rs2 0x0000BEEF -> wdata 0xBEEFBEEF, be 1100, we=1.
REQ-041 LW at addr 0x101 -> o_access_fault pulse, o_bus_req never rises, stall 0.
REQ-042 LHU at 0x002 with rdata 0xABCD0000 -> o_ld_data 0x0000ABCD; LH at the same address -> 0xFFFFABCD.
REQ-043 MEM_TIMEOUT_EN defined with TIMEOUT_CYCLES=4 and no ack -> o_bus_err pulses after 4 BUSY cycles and o_ld_data 0; with ack on cycle 4 -> no error.
REQ-044 i_rst asserted mid-BUSY -> next cycle IDLE with all outputs 0, and a spurious late ack is ignored.
